// File: rtl/oob_dev_ctrl.sv
// Device-side SATA OOB responder: answers host COMRESET with COMINIT and COMWAKE with COMWAKE,
// then runs the ALIGN/SYNC handshake and passes link-layer data once phy_ready is up.
module oob_dev_ctrl #(
    parameter int unsigned DATA_BYTE_WIDTH = 4,
    parameter logic [15:0] COMWAKE_TIMEOUT = 16'd65535,
    parameter logic [15:0] ALIGN_TIMEOUT   = 16'd4095,
    parameter logic [1:0]  SYNC_COUNT      = 2'd3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           gtx_ready,
    input  logic                           rxcominitdet,
    input  logic                           rxcomwakedet,
    input  logic                           rxelecidle,
    input  logic                           rxbyteisaligned,
    input  logic                           txcomfinish,
    output logic                           txcominit,
    output logic                           txcomwake,
    output logic                           txelecidle,
    input  logic [DATA_BYTE_WIDTH*8-1:0]   rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]     rxcharisk_in,
    input  logic [DATA_BYTE_WIDTH*8-1:0]   txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]     txcharisk_in,
    output logic [DATA_BYTE_WIDTH*8-1:0]   txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]     txcharisk_out,
    output logic [DATA_BYTE_WIDTH*8-1:0]   rxdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]     rxcharisk_out,
    output logic                           phy_ready,
    output logic [2:0]                     oob_state
);

    localparam logic [DATA_BYTE_WIDTH*8-1:0] ALIGN_PRIM = 32'h7B4A4ABC;
    localparam logic [DATA_BYTE_WIDTH*8-1:0] SYNC_PRIM  = 32'hB5B5957C;
    localparam logic [DATA_BYTE_WIDTH*8-1:0] D10_2      = 32'h4A4A4A4A;
    localparam logic [DATA_BYTE_WIDTH-1:0]   K_PRIM     = 4'b0001;

    typedef enum logic [3:0] {
        StIdle,
        StSendCominit,
        StWaitCominitDone,
        StWaitComwake,
        StSendComwake,
        StWaitComwakeDone,
        StSendAlign,
        StSendSync,
        StReady
    } state_e;

    state_e state_q, state_d;
    logic [15:0] timer_q, timer_d, timer_inc;
    logic [1:0]  sync_cnt_q, sync_cnt_d;
    logic [2:0]  idle_cnt_q, idle_cnt_d;

    logic                         txcominit_q, txcomwake_q, txelecidle_q, phy_ready_q;
    logic [DATA_BYTE_WIDTH*8-1:0] txdata_q, rxdata_q;
    logic [DATA_BYTE_WIDTH-1:0]   txcharisk_q, rxcharisk_q;

    logic rx_is_prim, rx_is_align, rx_is_sync;

    assign rx_is_prim  = rxbyteisaligned && (rxcharisk_in == K_PRIM);
    assign rx_is_align = rx_is_prim && (rxdata_in == ALIGN_PRIM);
    assign rx_is_sync  = rx_is_prim && !rx_is_align;

    always_comb begin
        state_d   = state_q;
        timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

        case (state_q)
            StIdle:            if (gtx_ready && rxcominitdet) state_d = StSendCominit;
            StSendCominit:     state_d = StWaitCominitDone;
            StWaitCominitDone: if (txcomfinish) state_d = StWaitComwake;
            StWaitComwake: begin
                if (rxcomwakedet)                        state_d = StSendComwake;
                else if (timer_inc == COMWAKE_TIMEOUT)   state_d = StIdle;
            end
            StSendComwake:     state_d = StWaitComwakeDone;
            StWaitComwakeDone: if (txcomfinish) state_d = StSendAlign;
            StSendAlign: begin
                if (rx_is_align)                         state_d = StSendSync;
                else if (timer_inc == ALIGN_TIMEOUT)     state_d = StIdle;
            end
            StSendSync: begin
                if (rx_is_sync && (sync_cnt_q + 2'd1) == SYNC_COUNT) state_d = StReady;
            end
            StReady:           if (rxelecidle && idle_cnt_q == 3'd7) state_d = StIdle;
            default:           state_d = StIdle;
        endcase

        // Host COMRESET outranks everything, including a GTX that has dropped ready.
        if (!gtx_ready) state_d = StIdle;
        if (state_q != StIdle && rxcominitdet) state_d = StSendCominit;

        timer_d = (state_d != state_q) ? 16'd0 : timer_inc;

        sync_cnt_d = 2'd0;
        if (state_d == state_q && state_q == StSendSync && rx_is_sync) begin
            sync_cnt_d = sync_cnt_q + 2'd1;
        end

        idle_cnt_d = 3'd0;
        if (state_d == state_q && state_q == StReady && rxelecidle) begin
            idle_cnt_d = idle_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= 16'd0;
            sync_cnt_q   <= 2'd0;
            idle_cnt_q   <= 3'd0;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            txelecidle_q <= 1'b1;
            phy_ready_q  <= 1'b0;
            txdata_q     <= '0;
            txcharisk_q  <= '0;
            rxdata_q     <= '0;
            rxcharisk_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sync_cnt_q   <= sync_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            // Burst requests fire as the send state hands over to its wait state.
            txcominit_q  <= (state_q == StSendCominit) && (state_d == StWaitCominitDone);
            txcomwake_q  <= (state_q == StSendComwake) && (state_d == StWaitComwakeDone);
            txelecidle_q <= !(state_d inside {StSendAlign, StSendSync, StReady});
            phy_ready_q  <= (state_d == StReady);

            case (state_d)
                StSendAlign: begin txdata_q <= ALIGN_PRIM; txcharisk_q <= K_PRIM;       end
                StSendSync:  begin txdata_q <= SYNC_PRIM;  txcharisk_q <= K_PRIM;       end
                StReady:     begin txdata_q <= txdata_in;  txcharisk_q <= txcharisk_in; end
                default:     begin txdata_q <= D10_2;      txcharisk_q <= '0;           end
            endcase

            if (state_d == StReady) begin
                rxdata_q    <= rxdata_in;
                rxcharisk_q <= rxcharisk_in;
            end else begin
                rxdata_q    <= '0;
                rxcharisk_q <= '0;
            end
        end
    end

    assign txcominit     = txcominit_q;
    assign txcomwake     = txcomwake_q;
    assign txelecidle    = txelecidle_q;
    assign phy_ready     = phy_ready_q;
    assign txdata_out    = txdata_q;
    assign txcharisk_out = txcharisk_q;
    assign rxdata_out    = rxdata_q;
    assign rxcharisk_out = rxcharisk_q;
    // Nine states on a 3-bit debug port: SEND_SYNC and READY both read 7, phy_ready splits them.
    assign oob_state     = (state_q == StReady) ? 3'd7 : state_q[2:0];

endmodule

// File: tb/tb_oob_dev_ctrl.sv
// Scoreboard bench for oob_dev_ctrl: stimulus queues cycle-stamped expectations, a negedge
// monitor retires them and checks rxdata_out against a queue of words sent while ready.
module tb_oob_dev_ctrl;

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;
    localparam logic [31:0] D10_2 = 32'h4A4A4A4A;

    localparam int S_STATE   = 0;
    localparam int S_COMINIT = 1;
    localparam int S_COMWAKE = 2;
    localparam int S_EIDLE   = 3;
    localparam int S_READY   = 4;
    localparam int S_TXDATA  = 5;
    localparam int S_TXK     = 6;
    localparam int S_RXDATA  = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, gtx_ready, rxcominitdet, rxcomwakedet, rxelecidle, rxbyteisaligned;
    logic        txcomfinish, txcominit, txcomwake, txelecidle, phy_ready;
    logic [31:0] rxdata_in, txdata_in, txdata_out, rxdata_out;
    logic [3:0]  rxcharisk_in, txcharisk_in, txcharisk_out, rxcharisk_out;
    logic [2:0]  oob_state;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          rx_track = 1'b0;
    exp_t        exp_q[$];
    logic [35:0] rxq[$];

    oob_dev_ctrl #(
        .COMWAKE_TIMEOUT(16'd100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gtx_ready       (gtx_ready),
        .rxcominitdet    (rxcominitdet),
        .rxcomwakedet    (rxcomwakedet),
        .rxelecidle      (rxelecidle),
        .rxbyteisaligned (rxbyteisaligned),
        .txcomfinish     (txcomfinish),
        .txcominit       (txcominit),
        .txcomwake       (txcomwake),
        .txelecidle      (txelecidle),
        .rxdata_in       (rxdata_in),
        .rxcharisk_in    (rxcharisk_in),
        .txdata_in       (txdata_in),
        .txcharisk_in    (txcharisk_in),
        .txdata_out      (txdata_out),
        .txcharisk_out   (txcharisk_out),
        .rxdata_out      (rxdata_out),
        .rxcharisk_out   (rxcharisk_out),
        .phy_ready       (phy_ready),
        .oob_state       (oob_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dut_val(input int sig);
        case (sig)
            S_STATE:   return {29'd0, oob_state};
            S_COMINIT: return {31'd0, txcominit};
            S_COMWAKE: return {31'd0, txcomwake};
            S_EIDLE:   return {31'd0, txelecidle};
            S_READY:   return {31'd0, phy_ready};
            S_TXDATA:  return txdata_out;
            S_TXK:     return {28'd0, txcharisk_out};
            default:   return rxdata_out;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        int idx;
        logic [31:0] act;
        logic [35:0] want;
        idx = 0;
        while (idx < exp_q.size()) begin
            if (exp_q[idx].cyc == cyc) begin
                act = dut_val(exp_q[idx].sig);
                vectors++;
                if (act !== exp_q[idx].val) begin
                    miscompares++;
                    $display("FAIL %s: got %h, want %h (cycle %0d)",
                             exp_q[idx].name, act, exp_q[idx].val, cyc);
                end
                exp_q.delete(idx);
            end else begin
                idx++;
            end
        end
        if (phy_ready === 1'b1) begin
            vectors++;
            if (rxq.size() == 0) begin
                miscompares++;
                $display("FAIL rx_path: phy_ready high with no word owed, got %h (cycle %0d)",
                         rxdata_out, cyc);
            end else begin
                want = rxq.pop_front();
                if ({rxcharisk_out, rxdata_out} !== want) begin
                    miscompares++;
                    $display("FAIL rx_path: got %h/%h, want %h/%h (cycle %0d)",
                             rxcharisk_out, rxdata_out, want[35:32], want[31:0], cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int sig, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drive_rx(input logic [31:0] d, input logic [3:0] k);
        rxdata_in    = d;
        rxcharisk_in = k;
        if (rx_track) rxq.push_back({k, d});
    endtask

    // From IDLE: host COMRESET, COMINIT burst, burst done; returns on WAIT_COMWAKE entry.
    task automatic go_wait_comwake();
        rxcominitdet = 1'b1;
        expect_at(1, S_STATE, 1, "enter_send_cominit");
        expect_at(1, S_COMINIT, 0, "cominit_not_early");
        tick();
        rxcominitdet = 1'b0;
        expect_at(1, S_COMINIT, 1, "cominit_pulse");
        expect_at(1, S_STATE, 2, "wait_cominit_done");
        expect_at(1, S_EIDLE, 1, "eidle_during_cominit");
        tick();
        expect_at(1, S_COMINIT, 0, "cominit_one_cycle");
        tick();
        txcomfinish = 1'b1;
        expect_at(1, S_STATE, 3, "enter_wait_comwake");
        tick();
        txcomfinish = 1'b0;
    endtask

    // From WAIT_COMWAKE: host COMWAKE now; returns on SEND_ALIGN entry.
    task automatic fire_comwake();
        rxcomwakedet = 1'b1;
        expect_at(1, S_STATE, 4, "enter_send_comwake");
        tick();
        rxcomwakedet = 1'b0;
        expect_at(1, S_COMWAKE, 1, "comwake_pulse");
        expect_at(1, S_STATE, 5, "wait_comwake_done");
        expect_at(2, S_COMWAKE, 0, "comwake_one_cycle");
        tick();
        tick();
        txcomfinish = 1'b1;
        expect_at(1, S_STATE, 6, "enter_send_align");
        expect_at(1, S_EIDLE, 0, "eidle_off_align");
        expect_at(1, S_TXDATA, ALIGN, "tx_align");
        expect_at(1, S_TXK, 1, "tx_align_k");
        tick();
        txcomfinish = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; gtx_ready = 1'b0; rxcominitdet = 1'b0; rxcomwakedet = 1'b0;
        rxelecidle = 1'b0; rxbyteisaligned = 1'b1; txcomfinish = 1'b0;
        rxdata_in = D10_2; rxcharisk_in = 4'd0; txdata_in = 32'd0; txcharisk_in = 4'd0;
        tick();
        tick();
        expect_at(0, S_STATE, 0, "rst_state");
        expect_at(0, S_EIDLE, 1, "rst_txelecidle");
        expect_at(0, S_TXDATA, 0, "rst_txdata");
        expect_at(0, S_TXK, 0, "rst_txk");
        expect_at(0, S_READY, 0, "rst_phy_ready");
        expect_at(0, S_COMINIT, 0, "rst_txcominit");
        expect_at(0, S_COMWAKE, 0, "rst_txcomwake");
        expect_at(0, S_RXDATA, 0, "rst_rxdata");
        tick();

        // COMRESET ignored while GTX not ready; stray txcomfinish ignored in IDLE.
        rst_n = 1'b1;
        rxcominitdet = 1'b1;
        expect_at(1, S_STATE, 0, "cominit_needs_gtx");
        expect_at(1, S_TXDATA, D10_2, "idle_d10_2");
        expect_at(1, S_TXK, 0, "idle_d10_2_k");
        tick();
        rxcominitdet = 1'b0;
        txcomfinish = 1'b1;
        expect_at(1, S_STATE, 0, "stray_txcomfinish");
        tick();
        txcomfinish = 1'b0;
        gtx_ready = 1'b1;
        repeat (4) tick();

        // Full handshake.
        go_wait_comwake();
        repeat (3) tick();
        fire_comwake();
        for (int i = 0; i < 19; i++) begin
            drive_rx(D10_2, 4'd0);
            if (i == 10) begin
                expect_at(1, S_TXDATA, ALIGN, "tx_align_hold");
                expect_at(1, S_RXDATA, 0, "rx_zero_align");
            end
            tick();
        end
        drive_rx(ALIGN, 4'b0001);
        expect_at(1, S_STATE, 7, "enter_send_sync");
        expect_at(1, S_TXDATA, SYNC, "tx_sync");
        tick();
        drive_rx(SYNC, 4'b0001);
        expect_at(1, S_READY, 0, "ready_after_1_sync");
        tick();
        drive_rx(SYNC, 4'b0001);
        expect_at(1, S_READY, 0, "ready_after_2_sync");
        expect_at(1, S_RXDATA, 0, "rx_zero_sync");
        tick();
        rx_track = 1'b1;
        drive_rx(SYNC, 4'b0001);
        expect_at(1, S_READY, 1, "ready_after_3_sync");
        expect_at(1, S_EIDLE, 0, "ready_eidle");
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = 32'hC0DE0000 + 32'(i);
            txdata_in    = v;
            txcharisk_in = 4'(i);
            drive_rx(32'hA5A50000 + 32'(i * 7), 4'(3 - i));
            expect_at(1, S_TXDATA, v, "ready_tx_pass");
            expect_at(1, S_TXK, 32'(i), "ready_txk_pass");
            expect_at(1, S_STATE, 7, "ready_state");
            tick();
        end

        // COMRESET while READY.
        rx_track = 1'b0;
        txdata_in = 32'hDEADBEEF;
        drive_rx(32'h12345678, 4'd0);
        rxcominitdet = 1'b1;
        expect_at(1, S_READY, 0, "reset_in_ready_drop");
        expect_at(1, S_EIDLE, 1, "reset_in_ready_eidle");
        expect_at(1, S_TXDATA, D10_2, "reset_in_ready_tx");
        expect_at(1, S_RXDATA, 0, "reset_in_ready_rx");
        expect_at(1, S_STATE, 1, "reset_in_ready_state");
        expect_at(1, S_COMINIT, 0, "reset_in_ready_cominit_lag");
        expect_at(2, S_COMINIT, 1, "reset_in_ready_cominit");
        expect_at(2, S_TXDATA, D10_2, "reset_in_ready_tx2");
        tick();
        rxcominitdet = 1'b0;
        tick();

        // COMWAKE timeout: IDLE exactly 100 cycles after WAIT_COMWAKE entry.
        txcomfinish = 1'b1;
        tick();
        txcomfinish = 1'b0;
        expect_at(99, S_STATE, 3, "comwake_timeout_early");
        expect_at(100, S_STATE, 0, "comwake_timeout");
        expect_at(100, S_EIDLE, 1, "comwake_timeout_eidle");
        repeat (100) tick();

        // COMWAKE on the timeout cycle wins.
        go_wait_comwake();
        repeat (99) tick();
        fire_comwake();

        // ALIGN timeout; misaligned or wrong-K ALIGN words must not match.
        for (int i = 0; i < 4095; i++) begin
            rxbyteisaligned = (i != 50);
            if (i == 50)      drive_rx(ALIGN, 4'b0001);
            else if (i == 60) drive_rx(ALIGN, 4'b0011);
            else              drive_rx(D10_2, 4'd0);
            if (i == 4093) begin
                expect_at(1, S_STATE, 6, "align_timeout_early");
                expect_at(1, S_EIDLE, 0, "align_timeout_early_eidle");
            end
            if (i == 4094) begin
                expect_at(1, S_STATE, 0, "align_timeout");
                expect_at(1, S_EIDLE, 1, "align_timeout_eidle");
                expect_at(1, S_TXDATA, D10_2, "align_timeout_tx");
            end
            tick();
        end
        rxbyteisaligned = 1'b1;

        // SYNC run broken by ALIGN, then READY and rxelecidle drop-out.
        go_wait_comwake();
        repeat (3) tick();
        fire_comwake();
        drive_rx(ALIGN, 4'b0001);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rx_track = 1'b1;
            drive_rx((i == 2) ? ALIGN : SYNC, 4'b0001);
            expect_at(1, S_READY, (i == 5) ? 32'd1 : 32'd0, "broken_sync_ready");
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            rxelecidle = (i != 7);
            drive_rx(32'h0BAD0000 + 32'(i), 4'd0);
            if (i == 15) begin
                expect_at(1, S_STATE, 0, "elecidle_exit");
                expect_at(1, S_READY, 0, "elecidle_drop");
            end else begin
                expect_at(1, S_READY, 1, "elecidle_hold");
            end
            tick();
        end
        rxq.delete();
        rx_track = 1'b0;
        rxelecidle = 1'b0;
        tick();

        // GTX loses ready mid-sequence.
        go_wait_comwake();
        tick();
        gtx_ready = 1'b0;
        expect_at(1, S_STATE, 0, "gtx_drop");
        tick();
        gtx_ready = 1'b1;
        tick();

        // Synchronous reset in SEND_SYNC.
        go_wait_comwake();
        repeat (3) tick();
        fire_comwake();
        drive_rx(ALIGN, 4'b0001);
        tick();
        rst_n = 1'b0;
        expect_at(1, S_STATE, 0, "midreset_state");
        expect_at(1, S_EIDLE, 1, "midreset_eidle");
        expect_at(1, S_TXDATA, 0, "midreset_txdata");
        expect_at(1, S_TXK, 0, "midreset_txk");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked, want %h at cycle %0d", e.name, e.val, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
